// File: rtl/dequeue_arbiter_if.sv
// Handshake bundle between the dequeue arbiter and the PIFO calendars,
// packet buffers and downstream ports it serves.
interface dequeue_arbiter_if #(
    parameter int NUM_PORTS  = 5,
    parameter int PORT_IDX_W = 3
);
    logic [NUM_PORTS-1:0]  s_axis_pifo_empty;
    logic [NUM_PORTS-1:0]  s_axis_tx_ready;
    logic                  s_axis_pifo_out_valid;
    logic                  s_axis_buffer_rd_valid;
    logic                  s_axis_buffer_rd_last;
    logic [NUM_PORTS-1:0]  m_axis_ctl_pifo_out_en;
    logic [NUM_PORTS-1:0]  m_axis_ctl_buffer_rd_en;
    logic [PORT_IDX_W-1:0] m_axis_grant_port;
    logic                  m_axis_busy;
    logic                  m_axis_err_timeout;

    // Handshake: a buffer beat transfers only in a cycle where the arbiter
    // holds rd_en for the granted port and the buffer presents rd_valid; a
    // pop response is taken only while the arbiter waits for it.

    // The arbiter side.
    modport slave (
        input  s_axis_pifo_empty,
        input  s_axis_tx_ready,
        input  s_axis_pifo_out_valid,
        input  s_axis_buffer_rd_valid,
        input  s_axis_buffer_rd_last,
        output m_axis_ctl_pifo_out_en,
        output m_axis_ctl_buffer_rd_en,
        output m_axis_grant_port,
        output m_axis_busy,
        output m_axis_err_timeout
    );

    // The calendar/buffer/port side.
    modport master (
        output s_axis_pifo_empty,
        output s_axis_tx_ready,
        output s_axis_pifo_out_valid,
        output s_axis_buffer_rd_valid,
        output s_axis_buffer_rd_last,
        input  m_axis_ctl_pifo_out_en,
        input  m_axis_ctl_buffer_rd_en,
        input  m_axis_grant_port,
        input  m_axis_busy,
        input  m_axis_err_timeout
    );
endinterface

// File: rtl/dequeue_arbiter.sv
// Round-robin dequeue scheduler: grants one eligible port, pops its PIFO
// calendar once and streams exactly one packet from its buffer.
module dequeue_arbiter #(
    parameter int NUM_PORTS   = 5,
    parameter int PORT_IDX_W  = 3,
    parameter int POP_TIMEOUT = 16
) (
    input  logic               axis_aclk,
    input  logic               axis_resetn,
    dequeue_arbiter_if.slave   bus,
    output logic [1:0]         dbg_state_o
);

    localparam int CNT_W = $clog2(POP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_READ = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PORT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PORT_IDX_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  err_q, err_d;

    logic [NUM_PORTS-1:0]  eligible;
    logic                  any_eligible;
    logic [PORT_IDX_W-1:0] pick;
    logic [NUM_PORTS-1:0]  grant_oh;
    logic [PORT_IDX_W-1:0] grant_next;
    logic                  beat_ok;
    logic                  last_beat;
    logic                  pop_expired;
    int                    idx;

    assign eligible = ~bus.s_axis_pifo_empty & bus.s_axis_tx_ready;
    assign grant_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q;
    assign grant_next = (grant_q == PORT_IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    assign beat_ok     = (state_q == ST_READ) && bus.s_axis_tx_ready[grant_q]
                         && bus.s_axis_buffer_rd_valid;
    assign last_beat   = beat_ok && bus.s_axis_buffer_rd_last;
    assign pop_expired = (tmo_cnt_q == CNT_W'(POP_TIMEOUT - 1));

    // Search upward from rr_ptr with wrap; first hit wins.
    always_comb begin
        any_eligible = 1'b0;
        pick         = '0;
        idx          = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!any_eligible && eligible[idx]) begin
                any_eligible = 1'b1;
                pick         = PORT_IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        tmo_cnt_d = '0;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_eligible) begin
                    grant_d = pick;
                    state_d = ST_POP;
                end
            end
            ST_POP: state_d = ST_WAIT;
            ST_WAIT: begin
                // A response arriving in the last allowed cycle still wins.
                if (bus.s_axis_pifo_out_valid) begin
                    state_d = ST_READ;
                end else if (pop_expired) begin
                    err_d    = 1'b1;
                    rr_ptr_d = grant_next;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                if (last_beat) begin
                    rr_ptr_d = grant_next;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Enables decode straight from registered state so reset drops them at once.
    always_comb begin
        bus.m_axis_ctl_pifo_out_en  = '0;
        bus.m_axis_ctl_buffer_rd_en = '0;
        if (state_q == ST_POP) bus.m_axis_ctl_pifo_out_en = grant_oh;
        if (state_q == ST_READ && bus.s_axis_tx_ready[grant_q])
            bus.m_axis_ctl_buffer_rd_en = grant_oh;
        bus.m_axis_grant_port  = grant_q;
        bus.m_axis_busy        = (state_q != ST_IDLE);
        bus.m_axis_err_timeout = err_q;
        dbg_state_o            = state_q;
    end

    a_pop_onehot0: assert property (@(posedge axis_aclk) disable iff (!axis_resetn)
        $onehot0(bus.m_axis_ctl_pifo_out_en));
    a_rd_onehot0: assert property (@(posedge axis_aclk) disable iff (!axis_resetn)
        $onehot0(bus.m_axis_ctl_buffer_rd_en));
    a_grant_range: assert property (@(posedge axis_aclk) disable iff (!axis_resetn)
        grant_q < PORT_IDX_W'(NUM_PORTS) && rr_ptr_q < PORT_IDX_W'(NUM_PORTS));

endmodule

// File: tb/tb_dequeue_arbiter.sv
// Directed bench for dequeue_arbiter: a monitor checks every pop pulse
// against a queue of expected grants pushed by the stimulus.
module tb_dequeue_arbiter;
  localparam int NP = 5;
  localparam int IW = 3;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  dequeue_arbiter_if #(.NUM_PORTS(NP), .PORT_IDX_W(IW)) bus ();

  dequeue_arbiter #(.NUM_PORTS(NP), .PORT_IDX_W(IW), .POP_TIMEOUT(16)) dut (
    .axis_aclk   (clk),
    .axis_resetn (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  logic [IW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every pop pulse must match the next expected grant
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.m_axis_ctl_pifo_out_en !== '0) begin
      logic [IW-1:0] e;
      logic [NP-1:0] oh;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(bus.m_axis_ctl_pifo_out_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        oh = 5'b00001 << e;
        chk("pop_grant", 32'(bus.m_axis_grant_port), 32'(e));
        chk("pop_onehot", 32'(bus.m_axis_ctl_pifo_out_en), 32'(oh));
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_axis_pifo_empty = '1;
    bus.s_axis_tx_ready = '1;
    bus.s_axis_pifo_out_valid = 1'b0;
    bus.s_axis_buffer_rd_valid = 1'b0;
    bus.s_axis_buffer_rd_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.m_axis_busy), 32'd0);
    chk("rst_grant", 32'(bus.m_axis_grant_port), 32'd0);
    chk("rst_err", 32'(bus.m_axis_err_timeout), 32'd0);
    chk("rst_pop_en", 32'(bus.m_axis_ctl_pifo_out_en), 32'd0);
    chk("rst_rd_en", 32'(bus.m_axis_ctl_buffer_rd_en), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Returns at the negedge of the pop cycle; gap counts negedges waited.
  task automatic wait_pop(input int exp_gap);
    int gap;
    bit seen;
    gap = 0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      gap = i;
      if (bus.m_axis_ctl_pifo_out_en !== '0) seen = 1;
    end
    chk("pop_seen", 32'(seen), 32'd1);
    if (exp_gap > 0) chk("pop_latency", 32'(gap), 32'(exp_gap));
  endtask

  task automatic give_valid();
    @(posedge clk); #1;
    bus.s_axis_pifo_out_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_axis_pifo_out_valid = 1'b0;
  endtask

  task automatic serve(input logic [IW-1:0] g, input int nbeats, input int exp_gap,
                       input logic [NP-1:0] empty_after);
    int cnt;
    int guard;
    logic [NP-1:0] oh;
    oh = 5'b00001 << g;
    wait_pop(exp_gap);
    bus.s_axis_pifo_empty = empty_after;
    give_valid();
    cnt = 0;
    guard = 0;
    while (cnt < nbeats && guard < 100) begin
      bus.s_axis_buffer_rd_valid = 1'b1;
      bus.s_axis_buffer_rd_last = (cnt == nbeats - 1);
      @(negedge clk);
      if (guard == 0) chk("rd_en_first", 32'(bus.m_axis_ctl_buffer_rd_en), 32'(oh));
      if (bus.m_axis_ctl_buffer_rd_en !== '0) cnt++;
      guard++;
      if (cnt < nbeats) begin
        @(posedge clk); #1;
      end
    end
    chk("beats_done", 32'(cnt), 32'(nbeats));
    @(posedge clk); #1;
    bus.s_axis_buffer_rd_valid = 1'b0;
    bus.s_axis_buffer_rd_last = 1'b0;
    @(negedge clk);
    chk("idle_after_pkt", 32'(bus.m_axis_busy), 32'd0);
  endtask

  initial begin
    int p0;

    // 1: ports 1 and 3 eligible, 4-beat packets, grants 1,3,1
    do_reset();
    bus.s_axis_pifo_empty = 5'b10101;
    exp_q.push_back(3'd1);
    serve(3'd1, 4, 2, 5'b10101);
    exp_q.push_back(3'd3);
    serve(3'd3, 4, 1, 5'b10101);
    exp_q.push_back(3'd1);
    serve(3'd1, 4, 1, 5'b11111);

    // 2: all ports eligible, 1-beat packets, grants 0..4,0
    do_reset();
    p0 = pop_cnt;
    bus.s_axis_pifo_empty = 5'b00000;
    for (int i = 0; i < 6; i++) exp_q.push_back(3'(i % NP));
    for (int i = 0; i < 5; i++) serve(3'(i), 1, (i == 0) ? 2 : 1, 5'b00000);
    serve(3'd0, 1, 1, 5'b11111);
    chk("all_ports_pops", 32'(pop_cnt - p0), 32'd6);

    // 3: tx_ready[2] dropped for 3 cycles mid-packet
    do_reset();
    bus.s_axis_pifo_empty = 5'b11011;
    exp_q.push_back(3'd2);
    wait_pop(2);
    bus.s_axis_pifo_empty = 5'b11111;
    give_valid();
    bus.s_axis_buffer_rd_valid = 1'b1;
    @(negedge clk);
    chk("txr_beat0", 32'(bus.m_axis_ctl_buffer_rd_en), 32'h04);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.s_axis_tx_ready = 5'b11011;
      bus.s_axis_buffer_rd_last = 1'b1;
      @(negedge clk);
      chk("txr_gap_rd_en", 32'(bus.m_axis_ctl_buffer_rd_en), 32'd0);
      chk("txr_gap_busy", 32'(bus.m_axis_busy), 32'd1);
    end
    @(posedge clk); #1;
    bus.s_axis_tx_ready = 5'b11111;
    bus.s_axis_buffer_rd_last = 1'b0;
    @(negedge clk);
    chk("txr_beat1", 32'(bus.m_axis_ctl_buffer_rd_en), 32'h04);
    @(posedge clk); #1;
    bus.s_axis_buffer_rd_last = 1'b1;
    @(negedge clk);
    chk("txr_last_busy", 32'(bus.m_axis_busy), 32'd1);
    @(posedge clk); #1;
    bus.s_axis_buffer_rd_valid = 1'b0;
    bus.s_axis_buffer_rd_last = 1'b0;
    @(negedge clk);
    chk("txr_done", 32'(bus.m_axis_busy), 32'd0);

    // 4: pop timeout on port 0, pointer moves on to port 1
    do_reset();
    bus.s_axis_pifo_empty = 5'b11100;
    exp_q.push_back(3'd0);
    wait_pop(2);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("tmo_wait_busy", 32'(bus.m_axis_busy), 32'd1);
      chk("tmo_wait_err", 32'(bus.m_axis_err_timeout), 32'd0);
    end
    @(negedge clk);
    chk("tmo_idle", 32'(bus.m_axis_busy), 32'd0);
    chk("tmo_err", 32'(bus.m_axis_err_timeout), 32'd1);
    exp_q.push_back(3'd1);
    serve(3'd1, 2, 1, 5'b11111);
    chk("tmo_err_sticky", 32'(bus.m_axis_err_timeout), 32'd1);

    // 5: port 0 goes empty during its READ
    do_reset();
    bus.s_axis_pifo_empty = 5'b11110;
    exp_q.push_back(3'd0);
    wait_pop(2);
    give_valid();
    bus.s_axis_buffer_rd_valid = 1'b1;
    @(negedge clk);
    chk("e0_beat0", 32'(bus.m_axis_ctl_buffer_rd_en), 32'h01);
    @(posedge clk); #1;
    bus.s_axis_pifo_empty = 5'b10111;
    bus.s_axis_buffer_rd_last = 1'b1;
    @(negedge clk);
    chk("e0_grant_held", 32'(bus.m_axis_grant_port), 32'd0);
    chk("e0_rd_en_held", 32'(bus.m_axis_ctl_buffer_rd_en), 32'h01);
    @(posedge clk); #1;
    bus.s_axis_buffer_rd_valid = 1'b0;
    bus.s_axis_buffer_rd_last = 1'b0;
    exp_q.push_back(3'd3);
    serve(3'd3, 1, 2, 5'b11111);

    // 6: reset pulse during READ clears the pointer
    do_reset();
    bus.s_axis_pifo_empty = 5'b10011;
    exp_q.push_back(3'd2);
    serve(3'd2, 2, 2, 5'b10011);
    exp_q.push_back(3'd3);
    wait_pop(1);
    give_valid();
    bus.s_axis_buffer_rd_valid = 1'b1;
    @(negedge clk);
    chk("rstmid_rd_en", 32'(bus.m_axis_ctl_buffer_rd_en), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rd_en_drop", 32'(bus.m_axis_ctl_buffer_rd_en), 32'd0);
    chk("rstmid_busy", 32'(bus.m_axis_busy), 32'd0);
    chk("rstmid_grant", 32'(bus.m_axis_grant_port), 32'd0);
    bus.s_axis_buffer_rd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(3'd2);
    serve(3'd2, 1, 2, 5'b11111);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dequeue_arbiter.md
# dequeue_arbiter

Round-robin dequeue scheduler for the per-port PIFO calendars and packet buffers of the NetFPGA PIFO scheduler (root-only build). It is the read-side counterpart of the enqueue agent. It selects one eligible output port at a time, pops that port's PIFO calendar once, and holds the matching buffer read enable until exactly one packet has been streamed out. It then advances the round-robin pointer. Ports are served one packet at a time, never interleaved.

## Interface
Parameters:
- NUM_PORTS, 5, number of output ports / PIFO calendars / buffers
- PORT_IDX_W, 3, width of port index (ceil(log2(NUM_PORTS)))
- POP_TIMEOUT, 16, max cycles to wait for PIFO pop response before abort

Ports:
- axis_aclk  in  1  clock; single clock domain
- axis_resetn  in  1  reset, asynchronous assert, active-low
- s_axis_pifo_empty  in  NUM_PORTS  per-port calendar empty flag
- s_axis_tx_ready  in  NUM_PORTS  per-port downstream ready
- s_axis_pifo_out_valid  in  1  PIFO pop response (rank/descriptor presented)
- s_axis_buffer_rd_valid  in  1  buffer read beat valid
- s_axis_buffer_rd_last  in  1  buffer read beat is last of packet
- m_axis_ctl_pifo_out_en  out  NUM_PORTS  one-hot, one-cycle pop pulse
- m_axis_ctl_buffer_rd_en  out  NUM_PORTS  one-hot buffer read enable
- m_axis_grant_port  out  PORT_IDX_W  index of port being served
- m_axis_busy  out  1  high in any state other than IDLE
- m_axis_err_timeout  out  1  sticky; set on pop timeout, cleared only by reset

## Operation
- eligible[i] = ~s_axis_pifo_empty[i] & s_axis_tx_ready[i].
- States:
  - IDLE: if any eligible, grant = first eligible index at or after rr_ptr, searching upward with wrap from NUM_PORTS-1 to 0. Register the grant and go to POP. Otherwise stay in IDLE.
  - POP: m_axis_ctl_pifo_out_en[grant]=1 for exactly this cycle. Go to WAIT.
  - WAIT: wait for s_axis_pifo_out_valid, then go to READ. A valid in the cycle immediately after POP is accepted. The timeout counter counts WAIT cycles; if it reaches POP_TIMEOUT without valid, set err_timeout, go to IDLE, and set rr_ptr = grant+1 (wrap).
  - READ: m_axis_ctl_buffer_rd_en[grant] = s_axis_tx_ready[grant] (combinational gate on the registered state). A beat counts only when rd_en & rd_valid. On a counted beat with rd_last: go to IDLE, rr_ptr = grant+1 with wrap (NUM_PORTS-1 → 0).
- Eligibility is sampled only in IDLE. Changes to empty/ready of any port during POP/WAIT/READ do not alter the grant.
- s_axis_pifo_out_valid outside WAIT is ignored. rd_valid/rd_last outside READ are ignored.
- Reset values: state IDLE, rr_ptr 0, grant 0, timeout counter 0, all outputs 0, err_timeout 0.
- Asserting reset mid-operation aborts immediately: all enables drop asynchronously, and no pointer advance is retained.

## Timing
- Eligible seen in IDLE at cycle T → pifo_out_en pulse at T+1 → WAIT from T+2.
- Valid at cycle W in WAIT → READ from W+1. The rd_en for a port with tx_ready high appears in cycle W+1.
- A last beat counted at cycle L → IDLE at L+1. The next grant's pop is at L+2 at the earliest, giving a minimum 2-cycle gap between packets.
- The timeout fires in the WAIT cycle in which the count reaches POP_TIMEOUT; the design is in IDLE the next cycle.
- m_axis_grant_port is valid and stable while busy. It holds the last value in IDLE.
- Single-beat packet: rd_valid & rd_last in the first READ cycle is legal and exits READ after one cycle.

## Test plan
- Reset, then ports 1 and 3 non-empty with all tx_ready: pop pulse on bit 1. After valid and a 4-beat packet ending in last, port 3 is served next. Then port 1 again (wrap past 4 and 0). Grant sequence 1,3,1.
- All five ports eligible continuously, 1-beat packets: grants 0,1,2,3,4,0. Exactly one pop per packet, and pifo_out_en is never multi-hot.
- tx_ready[2] dropped for 3 cycles mid-packet on port 2: rd_en[2] is low for those 3 cycles; beats with rd_valid in that window are not counted; the packet completes only on a counted last.
- PIFO never returns valid, POP_TIMEOUT=16: err_timeout rises 16 WAIT cycles after the pop, busy falls next cycle, rr_ptr advances, and err_timeout stays high afterwards.
- Port 0 empty is asserted while port 0 is in READ: the grant is unchanged and the packet finishes. On return to IDLE, port 0 is skipped.
- axis_resetn pulsed low during READ: all outputs go to 0 immediately. After release, the first grant is the lowest-index eligible port (rr_ptr=0).
